// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: opcodes, FSM states and sizing defaults.
package alu_issue_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREGS_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_MOVE = 3'd4,
    OP_SWAP = 3'd5,
    OP_AND  = 3'd6,
    OP_OR   = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB1  = 3'd3,
    S_WB2  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Ops that retire two register writes (second one lands in WB2).
  function automatic logic has_wb2(alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_SWAP);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake from decode plus the operand/result bus toward the combinational alu.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       instr_op;
  logic [AW-1:0]    instr_rd1;
  logic [AW-1:0]    instr_rd2;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [WIDTH-1:0] alu_r15;

  modport master (
    input  instr_valid, instr_op, instr_rd1, instr_rd2, alu_op1, alu_op2, alu_r15,
    output instr_ready, alu_a, alu_b, alu_sel
  );

  modport slave (
    output instr_valid, instr_op, instr_rd1, instr_rd2, alu_op1, alu_op2, alu_r15,
    input  instr_ready, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// NREGS x WIDTH architectural register file: one write port, two operand reads, one debug read.
module alu_issue_ctrl_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [NREGS-1:0][WIDTH-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we && (waddr == AW'(i))) regs[i] <= wdata;
      end
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: owns the register file, sequences one instruction at a time through the alu
// and writes results back (READ -> EXEC -> WB1 -> [WB2] -> DONE).
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int ALU_LAT = 1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.master bus,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             done,
  output logic             err
);

  localparam logic [AW-1:0] R15 = AW'(NREGS - 1);

  state_e           state_q, state_d;
  alu_op_e          op_q;
  logic [AW-1:0]    rd1_q, rd2_q;
  logic [WIDTH-1:0] cap_op1, cap_op2, cap_r15;
  logic             err_q;

  // vld_pipe[0] marks READ; vld_pipe[k] is the k-th EXEC cycle, capture at ALU_LAT.
  logic [ALU_LAT:1] vld_q;
  logic [ALU_LAT:0] vld_pipe;
  assign vld_pipe = {vld_q, state_q == S_READ};

  logic             div0;
  assign div0 = (op_q == OP_DIV) && (bus.alu_b == '0);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata_a, rdata_b;

  alu_issue_ctrl_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (rd1_q),
    .rdata_a  (rdata_a),
    .raddr_b  (rd2_q),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vld_q       <= '0;
      op_q        <= OP_ADD;
      rd1_q       <= '0;
      rd2_q       <= '0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_sel <= '0;
      cap_op1     <= '0;
      cap_op2     <= '0;
      cap_r15     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_pipe[ALU_LAT-1:0];
      case (state_q)
        S_IDLE: if (bus.instr_valid) begin
          op_q  <= alu_op_e'(bus.instr_op);
          rd1_q <= bus.instr_rd1;
          rd2_q <= bus.instr_rd2;
          err_q <= 1'b0;
        end
        S_READ: begin
          bus.alu_a   <= rdata_a;
          bus.alu_b   <= rdata_b;
          bus.alu_sel <= op_q;
        end
        S_EXEC: if (vld_pipe[ALU_LAT]) begin
          cap_op1 <= bus.alu_op1;
          cap_op2 <= bus.alu_op2;
          cap_r15 <= bus.alu_r15;
          err_q   <= div0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    waddr   = ld_addr;
    wdata   = ld_data;
    case (state_q)
      S_IDLE: begin
        we = ld_en;
        if (bus.instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: if (vld_pipe[ALU_LAT]) state_d = div0 ? S_DONE : S_WB1;
      S_WB1: begin
        we      = 1'b1;
        waddr   = rd1_q;
        wdata   = cap_op1;
        state_d = has_wb2(op_q) ? S_WB2 : S_DONE;
      end
      S_WB2: begin
        we      = 1'b1;
        waddr   = (op_q == OP_SWAP) ? rd2_q : R15;
        wdata   = (op_q == OP_SWAP) ? cap_op2 : cap_r15;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.instr_ready = (state_q == S_IDLE) && !rst;
  assign done            = (state_q == S_DONE);
  assign err             = done && err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural alu; results read back through dbg_data.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic        done, err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(16), .AW(4)) bus ();

  alu_issue_ctrl #(.WIDTH(16), .NREGS(16), .ALU_LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .done     (done),
    .err      (err)
  );

  // Behavioural alu: signed mul/div, r15 carries product high / remainder.
  logic signed [31:0] prod;
  assign prod = $signed({{16{bus.alu_a[15]}}, bus.alu_a}) * $signed({{16{bus.alu_b[15]}}, bus.alu_b});

  always_comb begin
    bus.alu_op1 = '0;
    bus.alu_op2 = '0;
    bus.alu_r15 = '0;
    case (bus.alu_sel)
      3'd0: bus.alu_op1 = bus.alu_a + bus.alu_b;
      3'd1: bus.alu_op1 = bus.alu_a - bus.alu_b;
      3'd2: begin bus.alu_op1 = prod[15:0]; bus.alu_r15 = prod[31:16]; end
      3'd3: if (bus.alu_b != '0) begin
        bus.alu_op1 = $signed(bus.alu_a) / $signed(bus.alu_b);
        bus.alu_r15 = $signed(bus.alu_a) % $signed(bus.alu_b);
      end
      3'd4: bus.alu_op1 = bus.alu_b;
      3'd5: begin bus.alu_op1 = bus.alu_b; bus.alu_op2 = bus.alu_a; end
      3'd6: bus.alu_op1 = bus.alu_a & bus.alu_b;
      default: bus.alu_op1 = bus.alu_a | bus.alu_b;
    endcase
  end

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Issues one instruction; lat = cycles from handshake to done (-1 on timeout).
  task automatic issue(input logic [2:0] op, input logic [3:0] r1, input logic [3:0] r2,
                       input bit ld_busy, output int lat, output logic got_err);
    int w;
    lat = -1; got_err = 1'b0; w = 0;
    @(negedge clk);
    while (!bus.instr_ready && w < 20) begin @(negedge clk); w++; end
    bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_rd1 = r1; bus.instr_rd2 = r2;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    if (ld_busy) begin ld_en = 1'b1; ld_addr = 4'd11; ld_data = 16'h1234; end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin lat = n; got_err = err; break; end
    end
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.instr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", bus.instr_ready); end
    vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rst_done_err: got %b%b want 00", done, err); end
    vectors++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_sel !== 3'd0) begin
      miscompares++; $display("FAIL rst_alu_bus: got a=%h b=%h sel=%0d want 0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    dbg_addr = 4'd15; #1;
    vectors++; if (dbg_data !== 16'h0) begin miscompares++; $display("FAIL rst_r15: got %h want 0000", dbg_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready: got %b want 1", bus.instr_ready); end
  endtask

  task automatic test_add;
    int lat; logic e;
    load(4'd1, 16'd15); load(4'd2, 16'd10);
    issue(3'd0, 4'd1, 4'd2, 1'b0, lat, e);
    vectors++; if (lat !== 4 || e !== 1'b0) begin miscompares++; $display("FAIL add_lat: got lat=%0d err=%b want 4/0", lat, e); end
    dbg_addr = 4'd1; #1;
    vectors++; if (dbg_data !== 16'd25) begin miscompares++; $display("FAIL add_r1: got %h want 0019", dbg_data); end
    dbg_addr = 4'd2; #1;
    vectors++; if (dbg_data !== 16'd10) begin miscompares++; $display("FAIL add_r2: got %h want 000a", dbg_data); end
  endtask

  task automatic test_mul;
    int lat; logic e;
    load(4'd3, 16'd5); load(4'd4, 16'hFFFB);
    issue(3'd2, 4'd3, 4'd4, 1'b0, lat, e);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL mul_lat: got %0d want 5", lat); end
    dbg_addr = 4'd3; #1;
    vectors++; if (dbg_data !== 16'hFFE7) begin miscompares++; $display("FAIL mul_r3: got %h want ffe7", dbg_data); end
    dbg_addr = 4'd15; #1;
    vectors++; if (dbg_data !== 16'hFFFF) begin miscompares++; $display("FAIL mul_r15: got %h want ffff", dbg_data); end
  endtask

  task automatic test_div;
    int lat; logic e;
    load(4'd5, 16'd5); load(4'd6, 16'd2);
    issue(3'd3, 4'd5, 4'd6, 1'b0, lat, e);
    vectors++; if (lat !== 5 || e !== 1'b0) begin miscompares++; $display("FAIL div_lat: got lat=%0d err=%b want 5/0", lat, e); end
    dbg_addr = 4'd5; #1;
    vectors++; if (dbg_data !== 16'd2) begin miscompares++; $display("FAIL div_r5: got %h want 0002", dbg_data); end
    dbg_addr = 4'd15; #1;
    vectors++; if (dbg_data !== 16'd1) begin miscompares++; $display("FAIL div_r15: got %h want 0001", dbg_data); end
    // Divide by zero skips both writebacks: EXEC goes straight to DONE.
    load(4'd6, 16'd0);
    issue(3'd3, 4'd5, 4'd6, 1'b0, lat, e);
    vectors++; if (lat !== 3 || e !== 1'b1) begin miscompares++; $display("FAIL div0_err: got lat=%0d err=%b want 3/1", lat, e); end
    dbg_addr = 4'd5; #1;
    vectors++; if (dbg_data !== 16'd2) begin miscompares++; $display("FAIL div0_r5: got %h want 0002", dbg_data); end
    dbg_addr = 4'd15; #1;
    vectors++; if (dbg_data !== 16'd1) begin miscompares++; $display("FAIL div0_r15: got %h want 0001", dbg_data); end
    @(negedge clk);
    vectors++; if (err !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL div0_pulse: got done=%b err=%b want 0/0", done, err); end
  endtask

  task automatic test_swap;
    int lat; logic e;
    load(4'd7, 16'd100); load(4'd8, 16'd2);
    issue(3'd5, 4'd7, 4'd8, 1'b0, lat, e);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL swap_lat: got %0d want 5", lat); end
    dbg_addr = 4'd7; #1;
    vectors++; if (dbg_data !== 16'd2) begin miscompares++; $display("FAIL swap_r7: got %h want 0002", dbg_data); end
    dbg_addr = 4'd8; #1;
    vectors++; if (dbg_data !== 16'd100) begin miscompares++; $display("FAIL swap_r8: got %h want 0064", dbg_data); end
    issue(3'd5, 4'd7, 4'd7, 1'b0, lat, e);
    dbg_addr = 4'd7; #1;
    vectors++; if (dbg_data !== 16'd2) begin miscompares++; $display("FAIL swap_self: got %h want 0002", dbg_data); end
  endtask

  task automatic test_logic;
    int lat; logic e;
    load(4'd1, 16'd4); load(4'd2, 16'd2);
    issue(3'd6, 4'd1, 4'd2, 1'b0, lat, e);
    dbg_addr = 4'd1; #1;
    vectors++; if (lat !== 4 || dbg_data !== 16'd0) begin miscompares++; $display("FAIL and_4_2: got %h lat=%0d want 0000/4", dbg_data, lat); end
    load(4'd1, 16'd5); load(4'd2, 16'd4);
    issue(3'd6, 4'd1, 4'd2, 1'b0, lat, e);
    dbg_addr = 4'd1; #1;
    vectors++; if (dbg_data !== 16'd4) begin miscompares++; $display("FAIL and_5_4: got %h want 0004", dbg_data); end
    load(4'd1, 16'd4); load(4'd2, 16'd3);
    issue(3'd7, 4'd1, 4'd2, 1'b0, lat, e);
    dbg_addr = 4'd1; #1;
    vectors++; if (dbg_data !== 16'd7) begin miscompares++; $display("FAIL or_4_3: got %h want 0007", dbg_data); end
    load(4'd10, 16'd55);
    issue(3'd4, 4'd9, 4'd10, 1'b0, lat, e);
    dbg_addr = 4'd9; #1;
    vectors++; if (lat !== 4 || dbg_data !== 16'd55) begin miscompares++; $display("FAIL move_r9: got %h lat=%0d want 0037/4", dbg_data, lat); end
    // ld_en held high from READ through DONE must not touch r11.
    issue(3'd1, 4'd1, 4'd2, 1'b1, lat, e);
    dbg_addr = 4'd11; #1;
    vectors++; if (dbg_data !== 16'd0) begin miscompares++; $display("FAIL ld_busy_r11: got %h want 0000", dbg_data); end
    dbg_addr = 4'd1; #1;
    vectors++; if (dbg_data !== 16'd4) begin miscompares++; $display("FAIL sub_7_3: got %h want 0004", dbg_data); end
  endtask

  task automatic test_alias;
    int lat; logic e;
    // Load and accept in the same IDLE cycle: READ sees the loaded value (7+7).
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 4'd13; ld_data = 16'd7;
    bus.instr_valid = 1'b1; bus.instr_op = 3'd0; bus.instr_rd1 = 4'd13; bus.instr_rd2 = 4'd13;
    @(posedge clk); #1;
    ld_en = 1'b0; bus.instr_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin @(negedge clk); if (done) begin lat = n; break; end end
    dbg_addr = 4'd13; #1;
    vectors++; if (lat !== 4 || dbg_data !== 16'd14) begin miscompares++; $display("FAIL ld_and_issue: got %h lat=%0d want 000e/4", dbg_data, lat); end
    // mul into r15: WB2 (high half) overwrites WB1 (low half). 3 * -1 = 0xFFFF_FFFD.
    load(4'd15, 16'd3); load(4'd14, 16'hFFFF);
    issue(3'd2, 4'd15, 4'd14, 1'b0, lat, e);
    dbg_addr = 4'd15; #1;
    vectors++; if (dbg_data !== 16'hFFFF) begin miscompares++; $display("FAIL mul_rd1_r15: got %h want ffff", dbg_data); end
  endtask

  task automatic test_reset_mid;
    int errs;
    load(4'd3, 16'd6); load(4'd4, 16'd7);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_op = 3'd2; bus.instr_rd1 = 4'd3; bus.instr_rd2 = 4'd4;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    errs = 0;
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r); #1;
      if (dbg_data !== 16'h0) errs++;
    end
    vectors++; if (errs != 0) begin miscompares++; $display("FAIL rst_mid_regs: got %0d nonzero regs want 0", errs); end
    vectors++; if (done !== 1'b0 || bus.instr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ctl: got done=%b ready=%b want 0/0", done, bus.instr_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b want 1", bus.instr_ready); end
    errs = 0;
    repeat (6) begin @(negedge clk); if (done !== 1'b0) errs++; end
    vectors++; if (errs != 0) begin miscompares++; $display("FAIL rst_mid_nodone: got %0d done cycles want 0", errs); end
    dbg_addr = 4'd3; #1;
    vectors++; if (dbg_data !== 16'h0) begin miscompares++; $display("FAIL rst_mid_r3: got %h want 0000", dbg_data); end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_rd1   = '0;
    bus.instr_rd2   = '0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_swap();
    test_logic();
    test_alias();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
